// File: rtl/ttt_pkg.sv
// Shared constants and helpers for the three-mark tic-tac-toe datapath.
// Holds mark encodings, the "no cell" marker, the win-line table and the win check.
package ttt_pkg;

  localparam logic [1:0] MARK_X    = 2'b10;
  localparam logic [1:0] MARK_O    = 2'b01;
  localparam logic [1:0] MARK_NONE = 2'b00;
  localparam logic [3:0] CELL_NONE = 4'd15;
  localparam int         KEEP_DEFAULT = 3;

  typedef logic [8:0][1:0] board_t;

  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic has_win(input board_t b, input logic [1:0] m);
    logic w;
    w = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (b[WIN_LINES[l][0]] == m && b[WIN_LINES[l][1]] == m && b[WIN_LINES[l][2]] == m)
        w = 1'b1;
    end
    return w && (m != MARK_NONE);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Per-player history of occupied cells, oldest first; depth KEEP.
// On a push while full the caller pops in the same cycle, so the depth never overflows.
module move_fifo
  import ttt_pkg::*;
#(
  parameter  int KEEP = KEEP_DEFAULT,
  localparam int CW   = $clog2(KEEP + 1),
  localparam int PW   = (KEEP > 1) ? $clog2(KEEP) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [3:0]    din,
  output logic [3:0]    head,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [3:0]    mem [KEEP];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(KEEP - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < KEEP; i++) mem[i] <= CELL_NONE;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(KEEP));

endmodule

// File: rtl/board_eliminator.sv
// Board-state stage: places accepted moves, evicts each player's oldest mark
// beyond KEEP, and latches the first win detected on the post-eviction board.
module board_eliminator
  import ttt_pkg::*;
#(
  parameter  int KEEP = KEEP_DEFAULT,
  localparam int CW   = $clog2(KEEP + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] location,
  input  logic [1:0] mark,
  output logic [1:0] a0,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [3:0] evictX,
  output logic [3:0] evictO,
  output logic [1:0] winner,
  output logic       gameOver,
  output logic       illegal
);

  board_t        board, next_board;
  logic [5:0]    prev_sample;
  logic [1:0]    cell_val;
  logic          new_move, reject, accept, win_now;
  logic          is_x, is_o, evicting;
  logic [3:0]    head_x, head_o, head_mv;
  logic          full_x, full_o;
  logic [CW-1:0] count_x, count_o;

  assign is_x = (mark == MARK_X);
  assign is_o = (mark == MARK_O);

  move_fifo #(.KEEP(KEEP)) u_fifo_x (
    .clk(clk), .rst(rst), .push(accept && is_x), .pop(accept && is_x && full_x),
    .din(location), .head(head_x), .full(full_x), .count(count_x)
  );

  move_fifo #(.KEEP(KEEP)) u_fifo_o (
    .clk(clk), .rst(rst), .push(accept && is_o), .pop(accept && is_o && full_o),
    .din(location), .head(head_o), .full(full_o), .count(count_o)
  );

  assign evicting = is_x ? full_x : full_o;
  assign head_mv  = is_x ? head_x : head_o;

  // Eviction and placement form one update; the win check sees only its result.
  always_comb begin
    next_board = board;
    cell_val   = MARK_NONE;
    for (int i = 0; i < 9; i++)
      if (location == 4'(i)) cell_val = board[i];
    new_move = (mark != MARK_NONE) && ({mark, location} != prev_sample);
    reject   = new_move && ((location > 4'd8) || (mark == 2'b11) ||
                            (cell_val != MARK_NONE) || gameOver);
    accept   = new_move && !reject;
    if (accept) begin
      for (int i = 0; i < 9; i++)
        if (evicting && head_mv == 4'(i)) next_board[i] = MARK_NONE;
      for (int i = 0; i < 9; i++)
        if (location == 4'(i)) next_board[i] = mark;
    end
    win_now = accept && has_win(next_board, mark);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board       <= '0;
      prev_sample <= '0;
      winner      <= MARK_NONE;
      gameOver    <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      prev_sample <= {mark, location};
      illegal     <= reject;
      board       <= next_board;
      if (win_now) begin
        winner   <= mark;
        gameOver <= 1'b1;
      end
    end
  end

  assign evictX = (count_x == CW'(KEEP)) ? head_x : CELL_NONE;
  assign evictO = (count_o == CW'(KEEP)) ? head_o : CELL_NONE;

  assign a0 = board[0];
  assign a1 = board[1];
  assign a2 = board[2];
  assign a3 = board[3];
  assign a4 = board[4];
  assign a5 = board[5];
  assign a6 = board[6];
  assign a7 = board[7];
  assign a8 = board[8];

endmodule

// File: tb/tb_board_eliminator.sv
// Directed-vector bench for board_eliminator (KEEP = 3): a table of moves with
// hand-computed boards, plus a held-input sequence.
module tb_board_eliminator;

  logic       clk;
  logic       rst;
  logic [3:0] location;
  logic [1:0] mark;
  logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [3:0] evictX, evictO;
  logic [1:0] winner;
  logic       gameOver, illegal;

  int applied;
  int miscompares;

  board_eliminator #(.KEEP(3)) dut (
    .clk(clk), .rst(rst), .location(location), .mark(mark),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
    .evictX(evictX), .evictO(evictO), .winner(winner), .gameOver(gameOver), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board expectation is a 9-character picture, cell 0 first: 'X', 'O' or '.'.
  typedef struct {
    logic       rst;
    logic [1:0] mark;
    logic [3:0] loc;
    logic [71:0] board;
    logic [3:0] ex;
    logic [3:0] eo;
    logic [1:0] win;
    logic       go;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic [1:0] m, input logic [3:0] l,
                        input logic [71:0] b, input logic [3:0] ex, input logic [3:0] eo,
                        input logic [1:0] w, input logic go, input logic ill);
    vec_t v;
    v.rst = r; v.mark = m; v.loc = l; v.board = b;
    v.ex = ex; v.eo = eo; v.win = w; v.go = go; v.ill = ill;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] cellAt(input int i);
    case (i)
      0: return a0;
      1: return a1;
      2: return a2;
      3: return a3;
      4: return a4;
      5: return a5;
      6: return a6;
      7: return a7;
      default: return a8;
    endcase
  endfunction

  function automatic logic [1:0] charMark(input logic [71:0] b, input int i);
    logic [7:0] c;
    c = b[8*(8-i) +: 8];
    if (c == "X") return 2'b10;
    if (c == "O") return 2'b01;
    return 2'b00;
  endfunction

  task automatic applyStimulus(input logic r, input logic [1:0] m, input logic [3:0] l);
    @(negedge clk);
    rst      = r;
    mark     = m;
    location = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [17:0] act_b, exp_b;
    applied++;
    for (int i = 0; i < 9; i++) begin
      act_b[2*i +: 2] = cellAt(i);
      exp_b[2*i +: 2] = charMark(v.board, i);
    end
    if (act_b !== exp_b) begin
      miscompares++;
      $display("[TB] FAIL %s board: got %b expected %b (cell 8..0)", name, act_b, exp_b);
    end
    if (evictX !== v.ex || evictO !== v.eo) begin
      miscompares++;
      $display("[TB] FAIL %s evict: got X=%0d O=%0d expected X=%0d O=%0d",
               name, evictX, evictO, v.ex, v.eo);
    end
    if (winner !== v.win || gameOver !== v.go) begin
      miscompares++;
      $display("[TB] FAIL %s win: got winner=%b gameOver=%b expected winner=%b gameOver=%b",
               name, winner, gameOver, v.win, v.go);
    end
    if (illegal !== v.ill) begin
      miscompares++;
      $display("[TB] FAIL %s illegal: got %b expected %b", name, illegal, v.ill);
    end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    rst = 1'b1; mark = 2'b00; location = 4'd0;

    // Reset, then reset in the middle of play with a move on the same cycle.
    addVec(1, 2'b00, 0, ".........", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 0, "X........", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b01, 4, "X...O....", 15, 15, 2'b00, 0, 0);
    addVec(1, 2'b10, 1, ".........", 15, 15, 2'b00, 0, 0);
    // Eviction: X@2 drops X@0, so row 0-1-2 cannot complete.
    addVec(0, 2'b10, 0, "X........", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b01, 4, "X...O....", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 1, "XX..O....", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b01, 5, "XX..OO...", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 8, "XX..OO..X",  0, 15, 2'b00, 0, 0);
    addVec(0, 2'b01, 6, "XX..OOO.X",  0,  4, 2'b00, 0, 0);
    addVec(0, 2'b10, 2, ".XX.OOO.X",  1,  4, 2'b00, 0, 0);
    addVec(0, 2'b01, 0, "OXX..OO.X",  1,  5, 2'b00, 0, 0);
    addVec(1, 2'b00, 0, ".........", 15, 15, 2'b00, 0, 0);
    // Same player on consecutive moves; the fourth X evicts its first.
    addVec(0, 2'b10, 0, "X........", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 1, "XX.......", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 3, "XX.X.....",  0, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 2, ".XXX.....",  1, 15, 2'b00, 0, 0);
    addVec(1, 2'b00, 0, ".........", 15, 15, 2'b00, 0, 0);
    // X wins on row 0; later moves are rejected and the board is frozen.
    addVec(0, 2'b10, 0, "X........", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b01, 3, "X..O.....", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 1, "XX.O.....", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b01, 4, "XX.OO....", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 2, "XXXOO....",  0, 15, 2'b10, 1, 0);
    addVec(0, 2'b01, 8, "XXXOO....",  0, 15, 2'b10, 1, 1);
    addVec(0, 2'b00, 0, "XXXOO....",  0, 15, 2'b10, 1, 0);
    addVec(1, 2'b00, 0, ".........", 15, 15, 2'b00, 0, 0);
    // Occupied cell and bad encodings.
    addVec(0, 2'b01, 4, "....O....", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 4, "....O....", 15, 15, 2'b00, 0, 1);
    addVec(0, 2'b00, 0, "....O....", 15, 15, 2'b00, 0, 0);
    addVec(0, 2'b10, 9, "....O....", 15, 15, 2'b00, 0, 1);
    addVec(0, 2'b11, 2, "....O....", 15, 15, 2'b00, 0, 1);
    addVec(0, 2'b00, 0, "....O....", 15, 15, 2'b00, 0, 0);
    addVec(1, 2'b00, 0, ".........", 15, 15, 2'b00, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].mark, vecs[i].loc);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Held input: X@6 for 20 cycles places once and never flags illegal.
    begin
      vec_t v;
      for (int c = 0; c < 20; c++) begin
        applyStimulus(0, 2'b10, 6);
        applied++;
        if (illegal !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL held_illegal cycle %0d: got %b expected 0", c, illegal);
        end
      end
      v.rst = 0; v.mark = 2'b10; v.loc = 6; v.board = "......X..";
      v.ex = 15; v.eo = 15; v.win = 2'b00; v.go = 0; v.ill = 0;
      checkOutput("held_board", v);
      applyStimulus(0, 2'b00, 6);
      checkOutput("held_gap", v);
      applyStimulus(0, 2'b10, 6);
      v.ill = 1;
      checkOutput("held_rearm", v);
      applyStimulus(0, 2'b10, 6);
      v.ill = 0;
      checkOutput("held_pulse_end", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
